// File: rtl/index_set_clear_vector_if.sv
// Request/status bundle for index_set_clear_vector: set/clear/flush requests in,
// occupancy vector, population count, flags and query lookup out.
interface index_set_clear_vector_if #(
    parameter int VECTOR_LENGTH = 8
);
    logic                     flush;
    logic                     set_valid;
    logic [31:0]              set_index;
    logic                     clear_valid;
    logic [31:0]              clear_index;
    logic [31:0]              query_index;
    logic                     query_busy;
    logic [VECTOR_LENGTH-1:0] vector_output;
    logic [31:0]              set_count;
    logic                     full;
    logic                     empty;
    logic                     error_double_set;
    logic                     error_double_clear;
    logic                     error_range;

    modport master (
        output flush, set_valid, set_index, clear_valid, clear_index, query_index,
        input  query_busy, vector_output, set_count, full, empty,
               error_double_set, error_double_clear, error_range
    );

    modport slave (
        input  flush, set_valid, set_index, clear_valid, clear_index, query_index,
        output query_busy, vector_output, set_count, full, empty,
               error_double_set, error_double_clear, error_range
    );
endinterface

// File: rtl/index_set_clear_vector.sv
// Registered occupancy vector updated by one flush/clear/set per cycle, with popcount,
// full/empty and sticky error flags. Define SET_CLEAR_VECTOR_BYPASS_EN for a 0-latency query.
module index_set_clear_vector #(
    parameter int VECTOR_LENGTH = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    index_set_clear_vector_if.slave      bus
);
    logic [VECTOR_LENGTH-1:0] vector_q, vector_d;
    logic [31:0]              count_q, count_d;
    logic                     err_set_q, err_set_d;
    logic                     err_clr_q, err_clr_d;
    logic                     err_rng_q, err_rng_d;
    logic                     set_in_range, clr_in_range, same_index;
    logic                     set_old_bit, clr_old_bit;
    logic [VECTOR_LENGTH-1:0] query_vec;
    logic                     query_bit;

    always_comb begin
        set_in_range = bus.set_index < 32'(VECTOR_LENGTH);
        clr_in_range = bus.clear_index < 32'(VECTOR_LENGTH);
        same_index   = bus.set_valid && bus.clear_valid && set_in_range &&
                       (bus.set_index == bus.clear_index);
        set_old_bit  = 1'b0;
        clr_old_bit  = 1'b0;
        vector_d     = bus.flush ? '0 : vector_q;

        // Clear is applied before set so a same-index pair leaves the bit set.
        for (int i = 0; i < VECTOR_LENGTH; i++) begin
            if (bus.set_index == 32'(i)) set_old_bit = vector_q[i];
            if (bus.clear_index == 32'(i)) clr_old_bit = vector_q[i];
            if (bus.clear_valid && bus.clear_index == 32'(i)) vector_d[i] = 1'b0;
            if (bus.set_valid && bus.set_index == 32'(i)) vector_d[i] = 1'b1;
        end

        count_d = '0;
        for (int i = 0; i < VECTOR_LENGTH; i++) begin
            count_d = count_d + 32'(vector_d[i]);
        end

        // Flush and a same-index set/clear pair make the prior bit state irrelevant.
        err_set_d = err_set_q | (bus.set_valid && set_in_range && !bus.flush &&
                                 !same_index && set_old_bit);
        err_clr_d = err_clr_q | (bus.clear_valid && clr_in_range && !bus.flush &&
                                 !same_index && !clr_old_bit);
        err_rng_d = err_rng_q | (bus.set_valid && !set_in_range) |
                                (bus.clear_valid && !clr_in_range);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vector_q  <= '0;
            count_q   <= '0;
            err_set_q <= 1'b0;
            err_clr_q <= 1'b0;
            err_rng_q <= 1'b0;
        end else begin
            vector_q  <= vector_d;
            count_q   <= count_d;
            err_set_q <= err_set_d;
            err_clr_q <= err_clr_d;
            err_rng_q <= err_rng_d;
        end
    end

`ifdef SET_CLEAR_VECTOR_BYPASS_EN
    assign query_vec = vector_d;
`else
    assign query_vec = vector_q;
`endif

    always_comb begin
        query_bit = 1'b0;
        for (int i = 0; i < VECTOR_LENGTH; i++) begin
            if (bus.query_index == 32'(i)) query_bit = query_vec[i];
        end
    end

    assign bus.query_busy         = query_bit;
    assign bus.vector_output      = vector_q;
    assign bus.set_count          = count_q;
    assign bus.full               = (count_q == 32'(VECTOR_LENGTH));
    assign bus.empty              = (count_q == 32'd0);
    assign bus.error_double_set   = err_set_q;
    assign bus.error_double_clear = err_clr_q;
    assign bus.error_range        = err_rng_q;
endmodule
